quant_share_sched: RTL and testbench
====================================

Name: quant_share_sched

Overview:
- Time-multiplexes one shared quantizer pipeline (scale × input + bias, round-shift, saturate) among NUM_REQ requester streams. Each requester has its own scale/bias/shift config.
- The quantizer samples its cfg inputs at several pipeline stages. The config can therefore change only when the pipeline is empty, so this block grants whole bursts round-robin and drains the pipeline between owners.
- Sits between the per-head/per-core accumulator outputs and the single quantizer instance. Returns quantized results tagged with the owner id.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- IDATA_WIDTH, 24, accumulator data width into quantizer
- ODATA_BIT, 8, quantized output width
- CDATA_SCALE_WIDTH, 16, scale width
- CDATA_BIAS_WIDTH, 16, bias width
- CDATA_SHIFT_WIDTH, 5, shift width
- MAX_BURST, 64, max beats per grant before forced release
- INFLIGHT_WIDTH, 4, in-flight counter width; must hold the quantizer latency (4 + retiming stages)
- ID_WIDTH, $clog2(NUM_REQ), owner id width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  marks final beat of requester burst
- req_data  in  NUM_REQ*IDATA_WIDTH  flat per-requester data, requester k at [k*IDATA_WIDTH +: IDATA_WIDTH]
- req_ready  out  NUM_REQ  beat accepted when valid&ready
- cfg_scale  in  NUM_REQ*CDATA_SCALE_WIDTH  per-requester scale
- cfg_bias  in  NUM_REQ*CDATA_BIAS_WIDTH  per-requester bias
- cfg_shift  in  NUM_REQ*CDATA_SHIFT_WIDTH  per-requester shift
- q_idata  out  IDATA_WIDTH  to quantizer idata
- q_idata_valid  out  1  to quantizer idata_valid
- q_cfg_scale / q_cfg_bias / q_cfg_shift  out  scale/bias/shift widths  to quantizer cfg inputs
- q_odata  in  ODATA_BIT  from quantizer
- q_odata_valid  in  1  from quantizer
- out_data  out  ODATA_BIT  registered result
- out_valid  out  1  result strobe (no backpressure)
- out_id  out  ID_WIDTH  owner of out_data
- busy  out  1  state != IDLE or inflight != 0

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; inflight=0; owner=0; beat_cnt=0.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - If any req_valid, pick the first set bit searching from rr_ptr upward with wrap. Latch owner, latch owner's cfg into q_cfg_* registers, clear beat_cnt, go to GRANT.
  - No beat is accepted in the selection cycle.
- GRANT:
  - req_ready[owner] = 1; all other req_ready = 0.
  - On req_valid[owner]: register req_data into q_idata, pulse q_idata_valid next cycle, increment beat_cnt.
  - A deasserted valid is a bubble: grant is held and q_idata_valid = 0.
  - Exit to DRAIN on an accepted beat with req_last, or when beat_cnt reaches MAX_BURST-1 on an accepted beat (forced release).
  - On exit, rr_ptr = owner+1 (mod NUM_REQ).
- DRAIN:
  - All req_ready = 0; q_cfg_* held.
  - Return to IDLE when inflight == 0 and no q_idata_valid is pending.
  - The next grant may then be selected the following cycle.
- q_cfg_* change only in the IDLE selection cycle and are stable through GRANT and DRAIN.
- inflight counter:
  - +1 on q_idata_valid, −1 on q_odata_valid; both in the same cycle leaves it unchanged.
  - Underflow (q_odata_valid with inflight 0) is ignored and counter stays 0; an assertion flags it.
- Output path: out_data <= q_odata, out_valid <= q_odata_valid, out_id <= owner. This is one registered cycle.
- Owner is constant until drained, so results never carry a wrong id.
- Requester cfg changes during its own grant are ignored until its next grant.
- MAX_BURST=1 yields one beat per grant.
- rst mid-burst clears state and counters the same cycle. Any quantizer results arriving afterwards are dropped: out_valid is held 0 for INFLIGHT_WIDTH-limited flush window = 2^INFLIGHT_WIDTH−1 cycles after rst deassert.
- Throughput: 1 beat/cycle within a burst. Switch overhead = quantizer latency + 2 cycles.

Test Plan:
- Single requester 2, cfg scale=2 bias=0 shift=1, burst of 4 beats {10,11,12,13}, last on 13 → out_data {10,11,12,13}, all out_id=2, then busy falls and state returns to IDLE.
- Requesters 0 and 1 valid simultaneously, 3-beat bursts each, rr_ptr=0 → req 0 served first, DRAIN completes (inflight=0), then req 1; no q_cfg_* change while inflight≠0.
- Requester 3 streams continuously with no last, MAX_BURST=64, requester 1 waiting → forced release after 64 beats, requester 1 granted next, then requester 3 again.
- Owner drops valid for 5 cycles mid-burst → grant held, q_idata_valid low 5 cycles, beat order preserved, no other req_ready asserted.
- Rounding/saturation via shared pipe: cfg scale=1 bias=0 shift=1, beat 0x7FFF → out_data 0x7F (saturated), out_valid exactly one pulse.
- Assert rst during GRANT with 3 beats in flight → all outputs 0 next cycle, stray q_odata_valid pulses in flush window produce no out_valid, new request afterwards is granted normally.

Source files
------------

// File: rtl/quant_share_sched_if.sv
// quant_share_sched_if: requester, quantizer and result signals of the shared quantizer scheduler
interface quant_share_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int IDATA_WIDTH = 24,
  parameter int ODATA_BIT = 8,
  parameter int CDATA_SCALE_WIDTH = 16,
  parameter int CDATA_BIAS_WIDTH = 16,
  parameter int CDATA_SHIFT_WIDTH = 5,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ*IDATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*CDATA_SCALE_WIDTH-1:0] cfg_scale;
  logic [NUM_REQ*CDATA_BIAS_WIDTH-1:0] cfg_bias;
  logic [NUM_REQ*CDATA_SHIFT_WIDTH-1:0] cfg_shift;
  logic [IDATA_WIDTH-1:0] q_idata;
  logic q_idata_valid;
  logic [CDATA_SCALE_WIDTH-1:0] q_cfg_scale;
  logic [CDATA_BIAS_WIDTH-1:0] q_cfg_bias;
  logic [CDATA_SHIFT_WIDTH-1:0] q_cfg_shift;
  logic [ODATA_BIT-1:0] q_odata;
  logic q_odata_valid;
  logic [ODATA_BIT-1:0] out_data;
  logic out_valid;
  logic [ID_WIDTH-1:0] out_id;
  logic busy;
  modport master (
    output req_valid, req_last, req_data, cfg_scale, cfg_bias, cfg_shift, q_odata, q_odata_valid,
    input req_ready, q_idata, q_idata_valid, q_cfg_scale, q_cfg_bias, q_cfg_shift,
    input out_data, out_valid, out_id, busy
  );
  modport slave (
    input req_valid, req_last, req_data, cfg_scale, cfg_bias, cfg_shift, q_odata, q_odata_valid,
    output req_ready, q_idata, q_idata_valid, q_cfg_scale, q_cfg_bias, q_cfg_shift,
    output out_data, out_valid, out_id, busy
  );
endinterface

// File: rtl/quant_share_sched.sv
// quant_share_sched: round-robin burst arbiter sharing one quantizer pipeline, draining between owners
module quant_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int IDATA_WIDTH = 24,
  parameter int ODATA_BIT = 8,
  parameter int CDATA_SCALE_WIDTH = 16,
  parameter int CDATA_BIAS_WIDTH = 16,
  parameter int CDATA_SHIFT_WIDTH = 5,
  parameter int MAX_BURST = 64,
  parameter int INFLIGHT_WIDTH = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst,
  quant_share_sched_if.slave bus
);
  localparam int BCW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
  state_t state, state_nx;
  logic [ID_WIDTH-1:0] owner, rr_ptr, sel, owner_inc;
  logic [BCW-1:0] beat_cnt;
  logic [INFLIGHT_WIDTH-1:0] inflight, flush;
  logic sel_hit, accept, burst_end;
  always_comb begin
    sel = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!sel_hit && bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        sel_hit = 1'b1;
        sel = ID_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
      end
  end
  assign owner_inc = owner == ID_WIDTH'(NUM_REQ - 1) ? '0 : owner + 1'b1;
  assign accept = state == GRANT && bus.req_valid[owner];
  assign burst_end = accept && (bus.req_last[owner] || beat_cnt == BCW'(MAX_BURST - 1));
  // no new owner until post-reset strays have been flushed, so none of its results are dropped
  always_comb begin
    state_nx = state == IDLE ? (sel_hit && flush == '0 ? GRANT : IDLE)
             : state == GRANT ? (burst_end ? DRAIN : GRANT)
             : (inflight == '0 && !bus.q_idata_valid ? IDLE : DRAIN);
    bus.req_ready = '0;
    if (state == GRANT) bus.req_ready[owner] = 1'b1;
  end
  assign bus.busy = state != IDLE || inflight != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      beat_cnt <= '0;
      inflight <= '0;
      flush <= '1;
      bus.q_idata <= '0;
      bus.q_idata_valid <= 1'b0;
      bus.q_cfg_scale <= '0;
      bus.q_cfg_bias <= '0;
      bus.q_cfg_shift <= '0;
      bus.out_data <= '0;
      bus.out_valid <= 1'b0;
      bus.out_id <= '0;
    end else begin
      state <= state_nx;
      if (flush != '0) flush <= flush - 1'b1;
      if (state == IDLE && state_nx == GRANT) begin
        owner <= sel;
        beat_cnt <= '0;
        bus.q_cfg_scale <= bus.cfg_scale[sel*CDATA_SCALE_WIDTH +: CDATA_SCALE_WIDTH];
        bus.q_cfg_bias <= bus.cfg_bias[sel*CDATA_BIAS_WIDTH +: CDATA_BIAS_WIDTH];
        bus.q_cfg_shift <= bus.cfg_shift[sel*CDATA_SHIFT_WIDTH +: CDATA_SHIFT_WIDTH];
      end
      if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
        bus.q_idata <= bus.req_data[owner*IDATA_WIDTH +: IDATA_WIDTH];
      end
      if (burst_end) rr_ptr <= owner_inc;
      bus.q_idata_valid <= accept;
      if (bus.q_idata_valid && !bus.q_odata_valid) inflight <= inflight + 1'b1;
      else if (!bus.q_idata_valid && bus.q_odata_valid && inflight != '0) inflight <= inflight - 1'b1;
      bus.out_data <= bus.q_odata;
      bus.out_valid <= bus.q_odata_valid && flush == '0;
      bus.out_id <= owner;
    end
  end
  a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush != '0)
    !(bus.q_odata_valid && inflight == '0));
endmodule

// File: tb/tb_quant_share_sched.sv
// tb_quant_share_sched: directed bench with a 4-stage quantizer model and per-requester beat queues
module tb_quant_share_sched;
  localparam int NR = 4, IW = 24, OB = 8, SW = 16, BW = 16, HW = 5, LAT = 4;
  typedef struct {logic bub; logic [IW-1:0] d; logic last;} beat_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  quant_share_sched_if bus();
  quant_share_sched dut(.clk(clk), .rst(rst), .bus(bus));
  beat_t bq[NR][$];
  logic [NR-1:0] rdy_snap;
  logic pv[LAT];
  logic [OB-1:0] pd[LAT];
  logic [OB-1:0] got_d[$], exp_d[$];
  logic [1:0] got_id[$], exp_id[$];
  int iv_t[$];
  int stray_n = 0, n_chk = 0, n_fail = 0, cyc = 0, cfg_viol = 0, rdy_viol = 0;
  logic cfg_chk = 1'b0, log_iv = 1'b0, pipe_busy;
  logic [SW+BW+HW-1:0] cfg_prev = '0;
  function automatic logic [OB-1:0] quant(logic [IW-1:0] x, logic [SW-1:0] s, logic [BW-1:0] b, logic [HW-1:0] sh);
    longint v;
    v = longint'($signed(x)) * longint'($signed(s)) + longint'($signed(b));
    if (sh != 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    return v > 127 ? 8'h7f : v < -128 ? 8'h80 : v[7:0];
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_cfg(int k, logic [SW-1:0] s, logic [BW-1:0] b, logic [HW-1:0] sh);
    bus.cfg_scale[k*SW +: SW] = s;
    bus.cfg_bias[k*BW +: BW] = b;
    bus.cfg_shift[k*HW +: HW] = sh;
  endtask
  task automatic push(int k, logic [IW-1:0] d, logic last, logic bub = 1'b0);
    bq[k].push_back('{bub, d, last});
  endtask
  task automatic add_exp(logic [OB-1:0] d, logic [1:0] id);
    exp_d.push_back(d);
    exp_id.push_back(id);
  endtask
  function automatic bit all_empty();
    for (int k = 0; k < NR; k++) if (bq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction
  task automatic wait_done(string tag);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #3;
      if (i > 1 && !bus.busy && all_empty()) break;
    end
    repeat (2) @(posedge clk);
    #3;
    check({tag, "_busy"}, bus.busy, 0);
  endtask
  task automatic compare(string tag);
    check({tag, "_cnt"}, got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      check($sformatf("%s_d%0d", tag, i), got_d[i], exp_d[i]);
      check($sformatf("%s_id%0d", tag, i), got_id[i], exp_id[i]);
    end
    got_d.delete(); got_id.delete(); exp_d.delete(); exp_id.delete();
  endtask
  // environment: monitors, quantizer model and requester drivers all act on the falling edge
  initial begin
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    rdy_snap = '0;
    forever begin
      @(negedge clk);
      cyc++;
      pipe_busy = bus.q_idata_valid;
      for (int i = 0; i < LAT; i++) pipe_busy |= pv[i];
      if (cfg_chk && pipe_busy && {bus.q_cfg_scale, bus.q_cfg_bias, bus.q_cfg_shift} != cfg_prev) cfg_viol++;
      cfg_prev = {bus.q_cfg_scale, bus.q_cfg_bias, bus.q_cfg_shift};
      if ($countones(bus.req_ready) > 1) rdy_viol++;
      if (log_iv && bus.req_ready[2] && bq[0].size() != 0) rdy_viol++;
      if (log_iv && bus.q_idata_valid) iv_t.push_back(cyc);
      if (bus.out_valid) begin got_d.push_back(bus.out_data); got_id.push_back(bus.out_id); end
      bus.q_odata_valid = pv[LAT-1] || stray_n > 0;
      bus.q_odata = pv[LAT-1] ? pd[LAT-1] : 8'h55;
      if (stray_n > 0) stray_n--;
      for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
      pv[0] = bus.q_idata_valid;
      pd[0] = quant(bus.q_idata, bus.q_cfg_scale, bus.q_cfg_bias, bus.q_cfg_shift);
      for (int k = 0; k < NR; k++) begin
        if (bq[k].size() != 0 && rdy_snap[k]) void'(bq[k].pop_front());
        bus.req_valid[k] = bq[k].size() != 0 && !bq[k][0].bub;
        bus.req_last[k] = bq[k].size() != 0 && bq[k][0].last;
        bus.req_data[k*IW +: IW] = bq[k].size() != 0 ? bq[k][0].d : '0;
      end
      rdy_snap = bus.req_ready;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
    bus.cfg_scale = '0; bus.cfg_bias = '0; bus.cfg_shift = '0;
    bus.q_odata = '0; bus.q_odata_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_id", bus.out_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_q_ivalid", bus.q_idata_valid, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_q_scale", bus.q_cfg_scale, 0);
    rst = 1'b0;
    cfg_chk = 1'b1;
    // single requester burst
    set_cfg(2, 16'd2, 16'd0, 5'd1);
    for (int i = 10; i <= 13; i++) begin push(2, IW'(i), i == 13); add_exp(OB'(i), 2'd2); end
    wait_done("t1");
    compare("t1");
    // two simultaneous requesters, served in round-robin order
    set_cfg(0, 16'd1, 16'd0, 5'd0);
    set_cfg(1, 16'd1, 16'd4, 5'd0);
    for (int i = 0; i < 3; i++) begin push(0, IW'(i + 1), i == 2); push(1, IW'(i + 20), i == 2); end
    for (int i = 0; i < 3; i++) add_exp(OB'(i + 1), 2'd0);
    for (int i = 0; i < 3; i++) add_exp(OB'(i + 24), 2'd1);
    wait_done("t2");
    compare("t2");
    // forced release after MAX_BURST beats
    set_cfg(3, 16'd1, 16'd0, 5'd0);
    for (int i = 0; i < 70; i++) push(3, IW'(i), i == 69);
    push(1, 24'd100, 1'b0);
    push(1, 24'd101, 1'b1);
    for (int i = 0; i < 64; i++) add_exp(OB'(i), 2'd3);
    add_exp(8'd104, 2'd1);
    add_exp(8'd105, 2'd1);
    for (int i = 64; i < 70; i++) add_exp(OB'(i), 2'd3);
    wait_done("t3");
    compare("t3");
    // five-cycle bubble mid-burst with another requester waiting
    set_cfg(2, 16'd1, 16'd0, 5'd0);
    iv_t.delete();
    log_iv = 1'b1;
    push(0, 24'd1, 1'b0);
    push(0, 24'd2, 1'b0);
    for (int i = 0; i < 5; i++) push(0, 24'd0, 1'b0, 1'b1);
    push(0, 24'd3, 1'b0);
    push(0, 24'd4, 1'b1);
    push(2, 24'd50, 1'b1);
    for (int i = 1; i <= 4; i++) add_exp(OB'(i), 2'd0);
    add_exp(8'd50, 2'd2);
    wait_done("t4");
    log_iv = 1'b0;
    compare("t4");
    check("t4_iv_cnt", iv_t.size(), 5);
    if (iv_t.size() >= 4) begin
      check("t4_gap01", iv_t[1] - iv_t[0], 1);
      check("t4_gap12", iv_t[2] - iv_t[1], 6);
      check("t4_gap23", iv_t[3] - iv_t[2], 1);
    end
    // rounding and saturation
    set_cfg(1, 16'd1, 16'd0, 5'd1);
    push(1, 24'h7fff, 1'b1);
    add_exp(8'h7f, 2'd1);
    wait_done("t5");
    compare("t5");
    // reset mid-burst with beats in flight
    set_cfg(2, 16'd1, 16'd0, 5'd0);
    for (int i = 0; i < 10; i++) push(2, IW'(30 + i), i == 9);
    iv_t.delete();
    log_iv = 1'b1;
    for (int i = 0; i < 200 && iv_t.size() < 3; i++) begin @(posedge clk); #3; end
    log_iv = 1'b0;
    check("t6_inflight3", iv_t.size() >= 3, 1);
    rst = 1'b1;
    cfg_chk = 1'b0;
    for (int k = 0; k < NR; k++) bq[k].delete();
    @(posedge clk);
    #3;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_out_data", bus.out_data, 0);
    check("t6_out_id", bus.out_id, 0);
    check("t6_q_ivalid", bus.q_idata_valid, 0);
    check("t6_q_idata", bus.q_idata, 0);
    check("t6_q_scale", bus.q_cfg_scale, 0);
    check("t6_ready", bus.req_ready, 0);
    check("t6_busy", bus.busy, 0);
    rst = 1'b0;
    stray_n = 6;
    got_d.delete(); got_id.delete();
    repeat (15) @(posedge clk);
    #3;
    check("t6_flush_outv", got_d.size(), 0);
    cfg_chk = 1'b1;
    set_cfg(1, 16'd1, 16'd0, 5'd0);
    push(1, 24'd9, 1'b1);
    add_exp(8'd9, 2'd1);
    wait_done("t6b");
    compare("t6b");
    check("cfg_stable", cfg_viol, 0);
    check("ready_onehot", rdy_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
